// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared FSM encoding, default memory depth and address legality check
// for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    function automatic logic addr_legal(input logic [31:0] addr, input int depth_words);
        return (addr[1:0] == 2'b00) && (addr < 32'(4 * depth_words));
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; the pointer only matters when both ports ask.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic winner
);

    always_comb winner = (req0 && req1) ? pointer : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between two requesters, one transaction per
// three cycles (IDLE sample, ACCESS grant/memory, RESP completion).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_write_en,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t      state, state_nxt;
    logic        pointer, port, we_q, err_q, winner, legal;
    logic [31:0] addr_q, wdata_q, rdata_q;

    rr_pick2 u_pick (
        .req0    (req0),
        .req1    (req1),
        .pointer (pointer),
        .winner  (winner)
    );

    assign legal          = addr_legal(addr_q, DEPTH_WORDS);
    assign mem_read_addr  = addr_q;
    assign mem_write_addr = addr_q;
    assign mem_write_data = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pointer <= 1'b0;
            port    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (req0 || req1)) begin
                pointer <= ~winner;
                port    <= winner;
                we_q    <= winner ? we1 : we0;
                addr_q  <= winner ? addr1 : addr0;
                wdata_q <= winner ? wdata1 : wdata0;
            end
            if (state == ACCESS) begin
                rdata_q <= (legal && !we_q) ? mem_read_data : '0;
                err_q   <= !legal;
            end
        end
    end

    // Outputs decode from the registered state, so reset clears them without a clock.
    always_comb begin
        state_nxt    = IDLE;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        rvalid0      = 1'b0;
        rvalid1      = 1'b0;
        rdata0       = '0;
        rdata1       = '0;
        err0         = 1'b0;
        err1         = 1'b0;
        mem_write_en = 1'b0;
        case (state)
            IDLE: state_nxt = (req0 || req1) ? ACCESS : IDLE;
            ACCESS: begin
                state_nxt    = RESP;
                gnt0         = !port;
                gnt1         = port;
                mem_write_en = we_q && legal;
            end
            RESP: begin
                state_nxt = IDLE;
                rvalid0   = !port;
                rvalid1   = port;
                rdata0    = port ? '0 : rdata_q;
                rdata1    = port ? rdata_q : '0;
                err0      = !port && err_q;
                err1      = port && err_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level model (fixed 3-cycle timing, round-robin choice, reference memory).
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = $clog2(DW);

    logic        clk = 1'b0, reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_write_en;
    logic [31:0] rdata0, rdata1, mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    logic [31:0] mem [DW];
    logic        bd_we = 1'b0;
    logic [AW-1:0] bd_idx = '0;
    logic [31:0] bd_data = '0;
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH_WORDS(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .err0           (err0),
        .err1           (err1),
        .mem_write_en   (mem_write_en),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_read_addr[AW+1:2]];

    always @(posedge clk)
        if (mem_write_en) begin
            mem[mem_write_addr[AW+1:2]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end else if (bd_we) mem[bd_idx] <= bd_data;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        q0[$], q1[$];
    bit          extra1 = 1'b0;
    logic [31:0] ref_mem [DW];
    int          cyc, free_at, t_start, rv0_cyc, rv1_cyc;
    bit          ptr_m, t_active, t_port, t_we, t_legal, g0, g1;
    logic [31:0] t_addr, t_wdata, t_rdata, last_addr, last_wdata;
    logic [31:0] rd0_seen, rd1_seen, er0_seen, er1_seen;
    bit          glog[$];
    int          gcyc[$];
    int          n_assert = 0, n_fail = 0;

    function automatic bit legal(input logic [31:0] a);
        return a[1:0] == 2'b00 && a < 32'(4 * DW);
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = 32'($urandom_range(0, 35)) << 2;
        c.wdata = $urandom();
        if ($urandom_range(0, 7) == 0) c.addr = c.addr + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) c.addr = $urandom();
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; free_at = 0; ptr_m = 1'b0; t_active = 1'b0; g0 = 1'b0; g1 = 1'b0;
        last_addr = '0; last_wdata = '0; rv0_cyc = -1; rv1_cyc = -1;
        glog.delete(); gcyc.delete();
    endtask

    task automatic drive_inputs();
        req0 = q0.size() > 0;
        req1 = q1.size() > 0 || extra1;
        {we0, addr0, wdata0} = {1'b0, 32'h0, 32'h0};
        {we1, addr1, wdata1} = {1'b1, 32'h10, 32'hBAD0BAD0};
        if (q0.size() > 0) {we0, addr0, wdata0} = {q0[0].we, q0[0].addr, q0[0].wdata};
        if (q1.size() > 0) {we1, addr1, wdata1} = {q1[0].we, q1[0].addr, q1[0].wdata};
    endtask

    task automatic check_cycle();
        bit acc, rsp;
        acc = t_active && cyc == t_start + 1;
        rsp = t_active && cyc == t_start + 2;
        g0 = acc && !t_port;
        g1 = acc && t_port;
        check("gnt0", 32'(gnt0), 32'(g0));
        check("gnt1", 32'(gnt1), 32'(g1));
        check("mem_write_en", 32'(mem_write_en), 32'(acc && t_we && t_legal));
        check("mem_read_addr", mem_read_addr, last_addr);
        check("mem_write_addr", mem_write_addr, last_addr);
        check("mem_write_data", mem_write_data, last_wdata);
        check("rvalid0", 32'(rvalid0), 32'(rsp && !t_port));
        check("rvalid1", 32'(rvalid1), 32'(rsp && t_port));
        if (rsp && !t_port) begin
            check("err0", 32'(err0), 32'(!t_legal));
            check("rdata0", rdata0, t_rdata);
        end
        if (rsp && t_port) begin
            check("err1", 32'(err1), 32'(!t_legal));
            check("rdata1", rdata1, t_rdata);
        end
        if (gnt0 || gnt1) begin glog.push_back(gnt1); gcyc.push_back(cyc); end
        if (rvalid0) begin rv0_cyc = cyc; rd0_seen = rdata0; er0_seen = 32'(err0); end
        if (rvalid1) begin rv1_cyc = cyc; rd1_seen = rdata1; er1_seen = 32'(err1); end
    endtask

    task automatic model_step();
        if (t_active && cyc == t_start + 1 && t_we && t_legal) ref_mem[t_addr[AW+1:2]] = t_wdata;
        if (cyc >= free_at && (req0 || req1)) begin
            bit w;
            w = !req0 ? 1'b1 : (!req1 ? 1'b0 : ptr_m);
            ptr_m    = !w;
            t_active = 1'b1;
            t_port   = w;
            t_start  = cyc;
            free_at  = cyc + 3;
            t_we     = w ? we1 : we0;
            t_addr   = w ? addr1 : addr0;
            t_wdata  = w ? wdata1 : wdata0;
            t_legal  = legal(t_addr);
            t_rdata  = (t_legal && !t_we) ? ref_mem[t_addr[AW+1:2]] : 32'h0;
            last_addr  = t_addr;
            last_wdata = t_wdata;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (g0 && q0.size() > 0) void'(q0.pop_front());
        if (g1 && q1.size() > 0) void'(q1.pop_front());
        drive_inputs();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        drive_inputs();
        while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n >= max_cycles), 32'(0));
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        bd_we = 1'b1; bd_idx = AW'(idx); bd_data = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete(); extra1 = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'({gnt0, gnt1}), 32'(0));
        check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
        check("rst_err", 32'({err0, err1}), 32'(0));
        check("rst_rdata", rdata0 | rdata1, 32'h0);
        check("rst_wen", 32'(mem_write_en), 32'(0));
        check("rst_addr", mem_read_addr | mem_write_addr | mem_write_data, 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int w;
        logic [31:0] old;
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < DW; i++) preload(i, $urandom());
        preload(2, 32'hDEADBEEF);
        do_reset();

        q0.push_back('{1'b0, 32'h8, 32'h0});
        drain(20);
        check("single_gnt_port0", 32'(glog.size() == 1 && glog[0] == 1'b0), 32'(1));
        check("single_gnt_cycle", 32'(gcyc.size() > 0 ? gcyc[0] : -1), 32'(1));
        check("single_rvalid_cycle", 32'(rv0_cyc), 32'(2));
        check("single_rdata", rd0_seen, 32'hDEADBEEF);
        check("single_err", er0_seen, 32'h0);

        w = wr_cnt;
        q1.push_back('{1'b1, 32'h7C, 32'h12345678});
        q1.push_back('{1'b0, 32'h7C, 32'h0});
        drain(30);
        check("wr_rd_pulses", 32'(wr_cnt - w), 32'(1));
        check("wr_rd_data", rd1_seen, 32'h12345678);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b0, 32'(i * 4), 32'h0});
            q1.push_back('{1'b0, 32'(i * 8), 32'h0});
        end
        drain(60);
        check("contention_grants", 32'(glog.size()), 32'(8));
        for (int i = 0; i < 4; i++)
            if (glog.size() > i) check($sformatf("contention_order%0d", i), 32'(glog[i]), 32'(i % 2));

        w = wr_cnt;
        q0.push_back('{1'b1, 32'h6, 32'hA5A5A5A5});
        q1.push_back('{1'b0, 32'h80, 32'h0});
        drain(30);
        check("illegal_wen", 32'(wr_cnt - w), 32'(0));
        check("illegal_err0", er0_seen, 32'h1);
        check("illegal_rdata0", rd0_seen, 32'h0);
        check("illegal_err1", er1_seen, 32'h1);
        check("illegal_rdata1", rd1_seen, 32'h0);

        // req1 raised only while port 0's transaction is in flight, dropped before IDLE
        glog.delete();
        q0.push_back('{1'b0, 32'h20, 32'h0});
        drive_inputs();
        tick();
        extra1 = 1'b1;
        drive_inputs();
        tick();
        tick();
        extra1 = 1'b0;
        drive_inputs();
        repeat (3) tick();
        check("drop_grants", 32'(glog.size()), 32'(1));
        check("drop_port", 32'(glog.size() > 0 ? glog[0] : 1'b1), 32'(0));

        old = ref_mem[4];
        q1.push_back('{1'b1, 32'h10, ~old});
        drive_inputs();
        tick();
        #2;
        check("abort_wen_before", 32'(mem_write_en), 32'(1));
        reset = 1'b1;
        #1;
        check("abort_wen_async", 32'(mem_write_en), 32'(0));
        check("abort_gnt_async", 32'(gnt1), 32'(0));
        q1.delete();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("abort_word", mem[4], old);
        repeat (4) tick();
        check("abort_no_rvalid", 32'(rv1_cyc), 32'(-1));
        q1.push_back('{1'b0, 32'h10, 32'h0});
        drain(20);
        check("abort_readback", rd1_seen, old);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_cmd());
            if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_cmd());
            drive_inputs();
            tick();
        end
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
